sync_fifo_ctl: RTL and testbench

- Parametrised single-clock FIFO; successor to the MAC-core dual-clock FIFO for paths that share one clock domain.
- Adds the following over the earlier block:
  - Power-of-two depth derived from the pointer width.
  - Selectable show-ahead or normal read mode.
  - Programmable almost-full and almost-empty thresholds.
  - Sticky overflow and underflow flags.
  - Synchronous flush.
- Sits between MAC datapath stages as an elastic buffer, and feeds ILA-visible status.

---
 rtl/sync_fifo_ctl.sv | 109 ++++++++++
 tb/tb_sync_fifo_ctl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctl.sv
// Purpose : single-clock elastic FIFO between MAC datapath stages.
//           It provides occupancy flags and sticky overflow/underflow status.
// Latency : normal mode gives data 1 cycle after rden. In show-ahead mode the
//           head word is visible the cycle empty deasserts.
// Backpr. : writes are refused when full unless a read is accepted in the same
//           cycle. Reads are refused when empty. A refused request sets the
//           matching sticky flag.
//
// Ports:
//   clk, reset_    : clock and async active-low reset
//   clear          : synchronous flush (highest priority after reset_)
//   wren, datain   : write request and data
//   rden           : read request (acknowledge in show-ahead mode)
//   dataout        : read data
//   full, empty, almost_full, almost_empty, usedw : occupancy status
//   overflow, underflow : sticky refused-write / refused-read flags
module sync_fifo_ctl #(
   parameter int WIDTH     = 8,
   parameter int PTR       = 4,
   parameter int SHOWAHEAD = 0,
   parameter int AF_LEVEL  = 14,
   parameter int AE_LEVEL  = 2
) (
   input  logic             clk,
   input  logic             reset_,
   input  logic             clear,
   input  logic             wren,
   input  logic [WIDTH-1:0] datain,
   input  logic             rden,
   output logic [WIDTH-1:0] dataout,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [PTR:0]     usedw,
   output logic             overflow,
   output logic             underflow
);

   localparam int           DEPTH   = 1 << PTR;
   localparam logic [PTR:0] DEPTH_W = (PTR+1)'(DEPTH);
   localparam logic [PTR:0] AF_W    = (PTR+1)'(AF_LEVEL);
   localparam logic [PTR:0] AE_W    = (PTR+1)'(AE_LEVEL);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR:0]     wr_ptr;
   logic [PTR:0]     rd_ptr;
   logic [WIDTH-1:0] dout_q;
   logic             rd_acc;
   logic             wr_acc;

   // Pointers carry one extra bit, so the modulo difference is the exact
   // occupancy 0..DEPTH. No full/empty disambiguation is needed at the wrap.
   assign usedw        = wr_ptr - rd_ptr;
   assign full         = (usedw == DEPTH_W);
   assign empty        = (usedw == '0);
   assign almost_full  = (usedw >= AF_W);
   assign almost_empty = (usedw <= AE_W);

   assign rd_acc = rden & ~empty;
   // When full, a write can still land if the head word leaves on this edge.
   assign wr_acc = wren & (~full | rd_acc);

   // Storage has no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (wr_acc && !clear)
         mem[wr_ptr[PTR-1:0]] <= datain;
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         dout_q    <= '0;
      end else if (clear) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         dout_q    <= '0;
      end else begin
         if (wr_acc)
            wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) begin
            rd_ptr <= rd_ptr + 1'b1;
            dout_q <= mem[rd_ptr[PTR-1:0]];
         end
         if (wren && !wr_acc)
            overflow <= 1'b1;
         if (rden && !rd_acc)
            underflow <= 1'b1;
      end
   end

   generate
      if (SHOWAHEAD != 0) begin : g_showahead
         // The head word is read combinationally. It is forced to 0 while
         // empty, so reset and flush present a defined value. The flag lags
         // the write by one edge, so a freshly written head word is already
         // in memory when empty drops.
         assign dataout = empty ? '0 : mem[rd_ptr[PTR-1:0]];
      end else begin : g_normal
         assign dataout = dout_q;
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Directed bench for sync_fifo_ctl: normal-mode and show-ahead instances
// driven by the same stimulus, each checked where its behaviour differs.
module tb_sync_fifo_ctl;

   logic       clk = 1'b0;
   logic       reset_;
   logic       clear;
   logic       wren;
   logic       rden;
   logic [7:0] datain;

   logic [7:0] n_dout, s_dout;
   logic       n_full, n_empty, n_af, n_ae, n_ov, n_uf;
   logic       s_full, s_empty, s_af, s_ae, s_ov, s_uf;
   logic [4:0] n_usedw, s_usedw;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sync_fifo_ctl #(.WIDTH(8), .PTR(4), .SHOWAHEAD(0), .AF_LEVEL(14), .AE_LEVEL(2)) u_norm (
      .clk(clk), .reset_(reset_), .clear(clear), .wren(wren), .datain(datain),
      .rden(rden), .dataout(n_dout), .full(n_full), .empty(n_empty),
      .almost_full(n_af), .almost_empty(n_ae), .usedw(n_usedw),
      .overflow(n_ov), .underflow(n_uf));

   sync_fifo_ctl #(.WIDTH(8), .PTR(4), .SHOWAHEAD(1), .AF_LEVEL(14), .AE_LEVEL(2)) u_sa (
      .clk(clk), .reset_(reset_), .clear(clear), .wren(wren), .datain(datain),
      .rden(rden), .dataout(s_dout), .full(s_full), .empty(s_empty),
      .almost_full(s_af), .almost_empty(s_ae), .usedw(s_usedw),
      .overflow(s_ov), .underflow(s_uf));

   // One active edge, then sample 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1; wren = 1'b0; rden = 1'b0;
      tick();
      clear = 1'b0;
   endtask

   task automatic test_reset();
      reset_ = 1'b0; clear = 1'b0; wren = 1'b0; rden = 1'b0; datain = 8'h00;
      #2;
      checks++; if (n_usedw !== 5'd0) begin failures++; $display("FAIL reset_usedw got %0d want 0", n_usedw); end
      checks++; if ({n_empty, n_ae, n_full, n_af} !== 4'b1100) begin failures++; $display("FAIL reset_flags got %b want 1100", {n_empty, n_ae, n_full, n_af}); end
      checks++; if ({n_ov, n_uf, s_ov, s_uf} !== 4'b0000) begin failures++; $display("FAIL reset_sticky got %b want 0000", {n_ov, n_uf, s_ov, s_uf}); end
      checks++; if (n_dout !== 8'h00 || s_dout !== 8'h00) begin failures++; $display("FAIL reset_dataout got %h/%h want 00/00", n_dout, s_dout); end
      tick();
      #3 reset_ = 1'b1;
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 16; i++) begin
         wren = 1'b1; datain = 8'(i);
         tick();
         wren = 1'b0;
         checks++; if (n_usedw !== 5'(i)) begin failures++; $display("FAIL fill_usedw[%0d] got %0d want %0d", i, n_usedw, i); end
         checks++; if (n_af !== (i >= 14)) begin failures++; $display("FAIL fill_af[%0d] got %b want %b", i, n_af, (i >= 14)); end
         checks++; if (n_full !== (i == 16)) begin failures++; $display("FAIL fill_full[%0d] got %b want %b", i, n_full, (i == 16)); end
      end
      checks++; if (s_dout !== 8'h01) begin failures++; $display("FAIL fill_sa_head got %h want 01", s_dout); end
      wren = 1'b1; datain = 8'hAA;
      tick();
      wren = 1'b0;
      checks++; if (n_ov !== 1'b1) begin failures++; $display("FAIL overflow_set got %b want 1", n_ov); end
      checks++; if (n_usedw !== 5'd16) begin failures++; $display("FAIL overflow_usedw got %0d want 16", n_usedw); end
   endtask

   task automatic test_drain();
      for (int i = 1; i <= 16; i++) begin
         rden = 1'b1;
         tick();
         rden = 1'b0;
         checks++; if (n_dout !== 8'(i)) begin failures++; $display("FAIL drain_data[%0d] got %h want %h", i, n_dout, 8'(i)); end
         checks++; if (n_usedw !== 5'(16 - i)) begin failures++; $display("FAIL drain_usedw[%0d] got %0d want %0d", i, n_usedw, 16 - i); end
         checks++; if (n_empty !== (i == 16) || n_ae !== (i >= 14)) begin failures++; $display("FAIL drain_flags[%0d] got e=%b ae=%b want e=%b ae=%b", i, n_empty, n_ae, (i == 16), (i >= 14)); end
         if (i < 16) begin
            checks++; if (s_dout !== 8'(i + 1)) begin failures++; $display("FAIL drain_sa_head[%0d] got %h want %h", i, s_dout, 8'(i + 1)); end
         end
      end
      rden = 1'b1;
      tick();
      rden = 1'b0;
      checks++; if (n_uf !== 1'b1) begin failures++; $display("FAIL underflow_set got %b want 1", n_uf); end
      checks++; if (n_dout !== 8'h10) begin failures++; $display("FAIL underflow_hold got %h want 10", n_dout); end
      do_clear();
   endtask

   task automatic test_showahead();
      wren = 1'b1; datain = 8'h5A;
      tick();
      wren = 1'b0;
      checks++; if (s_empty !== 1'b0 || s_dout !== 8'h5A) begin failures++; $display("FAIL sa_first_word got e=%b d=%h want e=0 d=5a", s_empty, s_dout); end
      rden = 1'b1;
      tick();
      rden = 1'b0;
      checks++; if (s_empty !== 1'b1 || s_usedw !== 5'd0) begin failures++; $display("FAIL sa_ack got e=%b u=%0d want e=1 u=0", s_empty, s_usedw); end
   endtask

   task automatic test_back_to_back();
      do_clear();
      for (int i = 0; i < 16; i++) begin
         wren = 1'b1; datain = 8'(8'h20 + i);
         tick();
      end
      wren = 1'b0;
      for (int k = 0; k < 40; k++) begin
         wren = 1'b1; rden = 1'b1; datain = 8'(8'h30 + k);
         tick();
         checks++; if (n_dout !== 8'(8'h20 + k)) begin failures++; $display("FAIL b2b_data[%0d] got %h want %h", k, n_dout, 8'(8'h20 + k)); end
         checks++; if (n_usedw !== 5'd16 || n_ov !== 1'b0) begin failures++; $display("FAIL b2b_level[%0d] got u=%0d ov=%b want u=16 ov=0", k, n_usedw, n_ov); end
      end
      wren = 1'b0; rden = 1'b0;
      do_clear();
   endtask

   task automatic test_empty_rw();
      wren = 1'b1; datain = 8'h77;
      tick();
      wren = 1'b0; rden = 1'b1;
      tick();
      rden = 1'b0;
      wren = 1'b1; rden = 1'b1; datain = 8'h33;
      tick();
      wren = 1'b0; rden = 1'b0;
      checks++; if (n_usedw !== 5'd1 || n_uf !== 1'b1) begin failures++; $display("FAIL empty_rw got u=%0d uf=%b want u=1 uf=1", n_usedw, n_uf); end
      checks++; if (n_dout !== 8'h77) begin failures++; $display("FAIL empty_rw_hold got %h want 77", n_dout); end
      // Requests under clear are ignored and must not set the sticky flags.
      clear = 1'b1; wren = 1'b1; rden = 1'b1;
      tick();
      clear = 1'b0; wren = 1'b0; rden = 1'b0;
      checks++; if (n_usedw !== 5'd0 || n_uf !== 1'b0 || n_ov !== 1'b0) begin failures++; $display("FAIL clear_state got u=%0d uf=%b ov=%b want 0/0/0", n_usedw, n_uf, n_ov); end
      checks++; if (n_dout !== 8'h00) begin failures++; $display("FAIL clear_dataout got %h want 00", n_dout); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 7; i++) begin
         wren = 1'b1; datain = 8'(8'h40 + i);
         tick();
      end
      checks++; if (n_usedw !== 5'd7) begin failures++; $display("FAIL mid_level got %0d want 7", n_usedw); end
      datain = 8'h99;
      #2 reset_ = 1'b0;
      #1;
      checks++; if (n_usedw !== 5'd0 || n_empty !== 1'b1 || n_ae !== 1'b1) begin failures++; $display("FAIL async_reset got u=%0d e=%b ae=%b want 0/1/1", n_usedw, n_empty, n_ae); end
      checks++; if (n_dout !== 8'h00) begin failures++; $display("FAIL async_reset_dout got %h want 00", n_dout); end
      wren = 1'b0;
      tick();
      #2 reset_ = 1'b1;
      wren = 1'b1; datain = 8'hB1;
      tick();
      datain = 8'hB2;
      tick();
      wren = 1'b0;
      checks++; if (n_usedw !== 5'd2 || s_dout !== 8'hB1) begin failures++; $display("FAIL resume got u=%0d head=%h want u=2 head=b1", n_usedw, s_dout); end
      rden = 1'b1;
      tick();
      tick();
      rden = 1'b0;
      checks++; if (n_dout !== 8'hB2 || n_empty !== 1'b1) begin failures++; $display("FAIL resume_read got d=%h e=%b want d=b2 e=1", n_dout, n_empty); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_showahead();
      test_back_to_back();
      test_empty_rw();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
